// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Types and constants shared by the fetch stage, the hazard unit and the
// pipeline latches.
//   pipe_state_t  : pipeline latch control (STALL, ENABLE, NOP, FLUSH)
//   fetch_state_t : fetch-stage run state (FETCH, HALTED)
//   NOP_INSTR     : word presented by an empty fetch buffer
//   wordAlign     : clears the two byte-offset bits of an address
package cpu_types_pkg;

    typedef enum logic [1:0] {
        STALL  = 2'b00,
        ENABLE = 2'b01,
        NOP    = 2'b10,
        FLUSH  = 2'b11
    } pipe_state_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Instruction addresses are word aligned, so the low two bits are dropped.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Single-entry holding register for one fetched instruction and its PC+4.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   i_fill        : load i_instr/i_pc4 and mark the entry valid
//   i_drain       : entry consumed or flushed; empty the buffer
//   i_invalidate  : redirect; empty the buffer regardless of fill/drain
//   i_instr/i_pc4 : data loaded on a fill
//   o_instr/o_pc4 : buffered data (o_instr is NOP_WORD while empty)
//   o_valid       : buffer holds a real instruction
module fetch_buffer
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_fill,
    input  logic        i_drain,
    input  logic        i_invalidate,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    // Invalidate beats fill so a word arriving in a redirect cycle is dropped.
    // Fill beats drain: a fill alongside a drain is the back-to-back case, and
    // a fill alongside a flush can only happen while the buffer is already empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0000_0000;
        end else if (i_invalidate) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (i_drain) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage: owns the PC, issues imem reads, buffers one
// fetched word with its PC+4, applies redirects and freezes on halt.
// Ports:
//   CLK, RST                 : clock, asynchronous active-high reset
//   ihit, imemload           : imem read completion and returned word
//   imemREN, imemaddr        : imem read request and address (the PC)
//   fd_state                 : fetch-decode latch control (pipe_state_t)
//   redirect_en, redirect_pc : taken branch/jump and its target
//   halt                     : stop fetching permanently (until reset)
//   instr_fet, pc4_fet       : buffered instruction and its PC+4
//   fet_valid                : buffer holds a real instruction
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [1:0]  fd_state,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr_fet,
    output logic [31:0] pc4_fet,
    output logic        fet_valid
);

    fetch_state_t r_state;
    fetch_state_t w_nextState;
    pipe_state_t  w_fdState;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcPlus4;
    logic         w_consume;
    logic         w_readEn;
    logic         w_takeRedirect;
    logic         w_fill;
    logic         w_drain;

    assign w_fdState = pipe_state_t'(fd_state);
    assign w_pcPlus4 = r_pc + WORD_BYTES;
    assign w_consume = fet_valid & (w_fdState == ENABLE);
    assign w_fill    = w_readEn & ihit;
    assign w_drain   = w_consume | (w_fdState == FLUSH);

    // Run-state register; HALTED is only left through reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Halt wins over redirect. A read is only requested when the buffer is
    // free or is being emptied this cycle, so a stalled full buffer never
    // loses a returning word.
    always_comb begin
        w_nextState    = r_state;
        w_readEn       = 1'b0;
        w_takeRedirect = 1'b0;
        case (r_state)
            FETCH: begin
                if (halt) begin
                    w_nextState = HALTED;
                end else begin
                    w_takeRedirect = redirect_en;
                    w_readEn       = ~redirect_en & (~fet_valid | w_consume);
                end
            end
            HALTED: begin
                w_nextState = HALTED;
            end
        endcase
    end

    // PC register. A redirect replaces the PC and makes any same-cycle ihit
    // irrelevant; a completed read advances it by one word (wrapping mod 2^32).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc <= wordAlign(PC_INIT);
        end else if (w_takeRedirect) begin
            r_pc <= wordAlign(redirect_pc);
        end else if (w_fill) begin
            r_pc <= w_pcPlus4;
        end
    end

    assign imemREN  = w_readEn & ~RST;
    assign imemaddr = r_pc;

    fetch_buffer #(
        .NOP_WORD (NOP_WORD)
    ) u_buffer (
        .CLK          (CLK),
        .RST          (RST),
        .i_fill       (w_fill),
        .i_drain      (w_drain),
        .i_invalidate (w_takeRedirect),
        .i_instr      (imemload),
        .i_pc4        (w_pcPlus4),
        .o_instr      (instr_fet),
        .o_pc4        (pc4_fet),
        .o_valid      (fet_valid)
    );

endmodule
